aes_encipher_block_p: RTL and testbench
=======================================

# aes_encipher_block_p

Parametrised AES encipher round engine for the aes_speed core. It runs the initial, main and final rounds for 128-, 192- and 256-bit keys. The S-box datapath is narrowed to SBOX_WORDS 32-bit words per cycle to trade area against throughput. It sits between the core control and the key memory: it publishes the current round index and consumes the matching 128-bit round key.

## Interface
- SBOX_WORDS, default 4: number of aes_sbox instances (words substituted per cycle). Legal values are 1, 2, 4; any other value is an elaboration error.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- next  in  1  start request, honoured only while ready=1.
- abort  in  1  cancels an operation in progress. Present only with AES_ENC_ABORT_EN.
- keylen  in  2  key length: 0=128, 1=192, 2=256, 3=reserved (treated as 256). Sampled when next is accepted.
- round  out  4  current round index, used to address the key memory.
- round_key  in  128  round key for the current round index.
- block  in  128  plaintext, sampled in the INIT cycle.
- new_block  out  128  state register; holds ciphertext when ready=1.
- ready  out  1  1 = idle or result valid.

## Operation
- Define W=SBOX_WORDS, P=4/W (cycles per round), Nr=10/12/14 from the latched keylen.
- FSM states: IDLE, INIT, MAIN.
  - IDLE→INIT on next. This clears round_ctr and word_ctr, latches keylen and drives ready←0.
  - INIT→MAIN after one cycle. block_reg←block^round_key and round_ctr←1.
  - MAIN persists for Nr rounds, each of P cycles, then returns to IDLE.
- MAIN S-box cycle k (word_ctr=k, k=0..P-1):
  - The S-boxes take block_reg words k·W…k·W+W-1 (word 0 = bits 127:96).
  - For k<P-1, the substituted words are written back in place and word_ctr increments.
  - For k=P-1, the full SubBytes state is block_reg with its last W words replaced by the S-box outputs. In the same cycle, ShiftRows (and MixColumns if round_ctr<Nr) and AddRoundKey are applied, then block_reg is written, round_ctr increments and word_ctr←0.
- Final round is round_ctr==Nr: there is no MixColumns, and ready←1 and state←IDLE at the same edge.
- round is constant for all P cycles of a round. round_key is used only in the last cycle of the round and in INIT.
- next while busy is ignored. keylen changes while busy have no effect.
- round_ctr is 4 bits. It never exceeds 15 (max value reached is Nr+1=15).
- new_block is held unchanged in IDLE until the next INIT.

## Timing
- Reset values: new_block=0, round=0, ready=1, FSM=IDLE, word_ctr=0, keylen_reg=0.
- With next accepted in cycle T:
  - ready=0 from T+1.
  - INIT in T+1.
  - Round r completes at the end of cycle T+1+r·P.
  - ready=1 and ciphertext are valid from T+2+Nr·P.
  - Example: W=4, 128-bit key gives ready in T+12. W=1, 256-bit key gives T+58.
- next is accepted in the same cycle ready is seen high. Back-to-back operation is allowed, with no dead cycle beyond IDLE.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). No partial result is retained.

## Configuration
- AES_ENC_ABORT_EN defined:
  - abort port exists.
  - abort=1 in INIT or MAIN forces, at the next edge: FSM←IDLE, ready←1, block_reg←0, round_ctr←0, word_ctr←0.
  - abort has priority over a completing final round.
  - abort together with next in IDLE means next is ignored.
- AES_ENC_ABORT_EN undefined: no abort port and no abort logic. Behaviour is otherwise identical.

## Structure
- Shared package aes_pkg holds:
  - keylen encodings and round counts (AES128/192/256_ROUNDS);
  - FSM state encodings;
  - functions gm2, gm3, mixw, mixcolumns, shiftrows, addroundkey.
- Sub-module: the existing aes_sbox, instantiated SBOX_WORDS times in a generate loop. The word select mux is driven by word_ctr.

## Test plan
- W=4, keylen=0. Key schedule model for key 000102…0f, plaintext 00112233445566778899aabbccddeeff → new_block=69c4e0d86a7b0430d8cdb78070b4c55a, ready high exactly 12 cycles after next.
- W=2, keylen=1. Key 000102…1617, same plaintext → dda97ca4864cdfe06eaf70a0ec0d7191, ready after 2+12·2=26 cycles. round holds each value for 2 cycles.
- W=1, keylen=2. Key 000102…1f, same plaintext → 8ea2b7ca516745bfeafc49904b496089, ready after 58 cycles.
- Busy robustness: pulse next and toggle keylen in MAIN → result and latency unchanged. Two back-to-back blocks both match the reference model.
- reset_n low in round 5 → new_block=0, round=0, ready=1 immediately. A following encryption is correct.
- AES_ENC_ABORT_EN build: abort in round 3 → the next cycle has ready=1, new_block=0, round=0. A subsequent next yields the correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the aes_speed encipher datapath.
//   - keylen encodings and the matching round counts
//   - encipher FSM state encoding
//   - the round functions: GF(2^8) doubling/tripling, MixColumns on a word
//     and on the full state, ShiftRows, AddRoundKey
//   - word accessors for the 128-bit state (word 0 = bits 127:96)
package aes_pkg;

  localparam logic [1:0] AES_KEY128 = 2'd0;
  localparam logic [1:0] AES_KEY192 = 2'd1;
  localparam logic [1:0] AES_KEY256 = 2'd2;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES192_ROUNDS = 4'd12;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  typedef enum logic [1:0] {
    AES_IDLE = 2'd0,
    AES_INIT = 2'd1,
    AES_MAIN = 2'd2
  } aes_state_e;

  // The reserved encoding 3 runs as a 256-bit key.
  function automatic logic [3:0] rounds_for(input logic [1:0] kl);
    case (kl)
      AES_KEY128: return AES128_ROUNDS;
      AES_KEY192: return AES192_ROUNDS;
      default:    return AES256_ROUNDS;
    endcase
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] x);
    return gm2(x) ^ x;
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
            b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127 - 32*c -: 32] = mixw(s[127 - 32*c -: 32]);
    end
    return r;
  endfunction

  // Row r of column c lives at byte r of word c; row r rotates left by r.
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 32*c - 8*row -: 8] = s[127 - 32*((c + row) % 4) - 8*row -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] s,
                                               input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] s, input logic [1:0] i);
    case (i)
      2'd0:    return s[127:96];
      2'd1:    return s[95:64];
      2'd2:    return s[63:32];
      default: return s[31:0];
    endcase
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] s, input logic [1:0] i,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = s;
    case (i)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box applied to the four bytes of one 32-bit word.
// Ports:
//   sboxw_i      32-bit word to substitute
//   new_sboxw_o  byte-wise substituted word
module aes_sbox (
  input  logic [31:0] sboxw_i,
  output logic [31:0] new_sboxw_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign new_sboxw_o = {SBOX[sboxw_i[31:24]], SBOX[sboxw_i[23:16]],
                        SBOX[sboxw_i[15:8]],  SBOX[sboxw_i[7:0]]};

endmodule

// File: rtl/aes_encipher_block_p.sv
// aes_encipher_block_p: AES encipher round engine with a narrowed S-box path.
// SBOX_WORDS (1, 2 or 4) words are substituted per cycle, so one round takes
// 4/SBOX_WORDS cycles. The engine publishes the round index to the key memory
// and consumes the matching 128-bit round key.
// Optional feature macro: AES_ENC_ABORT_EN adds the abort input.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   next          start request, honoured only while ready=1
//   abort         cancel an operation (AES_ENC_ABORT_EN builds only)
//   keylen        0=128, 1=192, 2/3=256; latched when next is accepted
//   round         current round index (key memory address)
//   round_key     round key for the current round index
//   block         plaintext, sampled in the INIT cycle
//   new_block     state register; ciphertext while ready=1
//   ready         idle / result valid
//   dbg_state_o   current FSM state, for checkers
// Handshake: next is a request qualified by ready; it is taken on the edge
// where next=1 and ready=1, after which ready stays 0 until the ciphertext is
// in new_block. No back-pressure exists on the result side.
module aes_encipher_block_p
  import aes_pkg::*;
#(
  parameter int SBOX_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
`ifdef AES_ENC_ABORT_EN
  input  logic         abort,
`endif
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output aes_state_e   dbg_state_o
);

  localparam int W = SBOX_WORDS;
  localparam int P = (W > 0) ? 4 / W : 1;
  localparam logic [1:0] LAST_WORD = 2'(P - 1);

  if (!(W == 1 || W == 2 || W == 4)) begin : g_bad_sbox_words
    $error("SBOX_WORDS must be 1, 2 or 4");
  end

  aes_state_e   state_q, state_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [1:0]   word_ctr_q, word_ctr_d;
  logic [1:0]   keylen_q, keylen_d;
  logic [127:0] block_q, block_d;
  logic         ready_q, ready_d;

  logic [3:0]   nr;
  logic         start;
  logic [127:0] sub_state;
  logic [127:0] shifted;

  // S-box lane j handles state word word_ctr*W + j.
  logic [1:0]  sel    [W];
  logic [31:0] sb_in  [W];
  logic [31:0] sb_out [W];

  for (genvar j = 0; j < W; j++) begin : g_sbox
    assign sel[j]   = 2'(int'(word_ctr_q) * W + j);
    assign sb_in[j] = get_word(block_q, sel[j]);
    aes_sbox u_sbox (
      .sboxw_i     (sb_in[j]),
      .new_sboxw_o (sb_out[j])
    );
  end

  // Earlier cycles of the round already substituted the other words in
  // place, so this is the full SubBytes state on the last cycle.
  always_comb begin
    sub_state = block_q;
    for (int j = 0; j < W; j++) begin
      sub_state = put_word(sub_state, sel[j], sb_out[j]);
    end
  end

  assign shifted = shiftrows(sub_state);
  assign nr      = rounds_for(keylen_q);

`ifdef AES_ENC_ABORT_EN
  assign start = next && !abort;
`else
  assign start = next;
`endif

  always_comb begin
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    word_ctr_d  = word_ctr_q;
    keylen_d    = keylen_q;
    block_d     = block_q;
    ready_d     = ready_q;

    case (state_q)
      AES_IDLE: begin
        if (start) begin
          keylen_d    = keylen;
          round_ctr_d = 4'd0;
          word_ctr_d  = 2'd0;
          ready_d     = 1'b0;
          state_d     = AES_INIT;
        end
      end
      AES_INIT: begin
        block_d     = addroundkey(block, round_key);
        round_ctr_d = 4'd1;
        state_d     = AES_MAIN;
      end
      AES_MAIN: begin
        if (word_ctr_q != LAST_WORD) begin
          block_d    = sub_state;
          word_ctr_d = word_ctr_q + 2'd1;
        end else begin
          if (round_ctr_q < nr) begin
            block_d = addroundkey(mixcolumns(shifted), round_key);
          end else begin
            block_d = addroundkey(shifted, round_key);
          end
          round_ctr_d = round_ctr_q + 4'd1;
          word_ctr_d  = 2'd0;
          if (round_ctr_q == nr) begin
            ready_d = 1'b1;
            state_d = AES_IDLE;
          end
        end
      end
      default: begin
        state_d = AES_IDLE;
        ready_d = 1'b1;
      end
    endcase

`ifdef AES_ENC_ABORT_EN
    // Overrides everything above, including a completing final round.
    if (abort && state_q != AES_IDLE) begin
      state_d     = AES_IDLE;
      ready_d     = 1'b1;
      block_d     = '0;
      round_ctr_d = 4'd0;
      word_ctr_d  = 2'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= AES_IDLE;
      round_ctr_q <= 4'd0;
      word_ctr_q  <= 2'd0;
      keylen_q    <= 2'd0;
      block_q     <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      word_ctr_q  <= word_ctr_d;
      keylen_q    <= keylen_d;
      block_q     <= block_d;
      ready_q     <= ready_d;
    end
  end

  assign round       = round_ctr_q;
  assign new_block   = block_q;
  assign ready       = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_encipher_block_p.sv
// tb_aes_encipher_block_p: directed bench for aes_encipher_block_p.
// Three engines (4, 2 and 1 S-box words) share clock, reset and plaintext.
// The bench computes the round keys itself (its own algebraic S-box and key
// expansion) and serves round_key[round] to each engine; ciphertexts are the
// published AES example vectors.
module tb_aes_encipher_block_p;
  import aes_pkg::*;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic         next_a   [3];
  logic [1:0]   keylen_a [3];
  wire  [3:0]   round_a  [3];
  wire  [127:0] rk_a     [3];
  wire  [127:0] nb_a     [3];
  wire          ready_a  [3];
  wire  [1:0]   st_a     [3];
  logic [127:0] pt;
  logic [127:0] ks [16];
`ifdef AES_ENC_ABORT_EN
  logic         abort;
`endif

  int tests;
  int fails;

  assign rk_a[0] = ks[round_a[0]];
  assign rk_a[1] = ks[round_a[1]];
  assign rk_a[2] = ks[round_a[2]];

  aes_encipher_block_p #(.SBOX_WORDS(4)) u_w4 (
    .clk(clk), .reset_n(reset_n), .next(next_a[0]),
`ifdef AES_ENC_ABORT_EN
    .abort(abort),
`endif
    .keylen(keylen_a[0]), .round(round_a[0]), .round_key(rk_a[0]), .block(pt),
    .new_block(nb_a[0]), .ready(ready_a[0]), .dbg_state_o(st_a[0]));

  aes_encipher_block_p #(.SBOX_WORDS(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .next(next_a[1]),
`ifdef AES_ENC_ABORT_EN
    .abort(abort),
`endif
    .keylen(keylen_a[1]), .round(round_a[1]), .round_key(rk_a[1]), .block(pt),
    .new_block(nb_a[1]), .ready(ready_a[1]), .dbg_state_o(st_a[1]));

  aes_encipher_block_p #(.SBOX_WORDS(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .next(next_a[2]),
`ifdef AES_ENC_ABORT_EN
    .abort(abort),
`endif
    .keylen(keylen_a[2]), .round(round_a[2]), .round_key(rk_a[2]), .block(pt),
    .new_block(nb_a[2]), .ready(ready_a[2]), .dbg_state_o(st_a[2]));

  // ---------------- reference key schedule ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // Multiplicative inverse as a^254, then the affine transform.
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv, e, s, r;
    inv = 8'h01;
    e   = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, e);
      e = gmul(e, e);
    end
    s = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      r = rotl1(r);
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  // Key bytes are 00,01,02,... for every key length.
  task automatic load_ks(input logic [1:0] kl);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
    nr = nk + 6;
    for (int i = 0; i < 64; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         ks[r] = '0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: request a start on the following posedge.
  task automatic kick(input int sel, input logic [1:0] kl);
    load_ks(kl);
    keylen_a[sel] = kl;
    next_a[sel]   = 1'b1;
  endtask

  // Follows a kick; returns at the negedge where ready is first seen high.
  task automatic run_enc(input int sel, input logic [1:0] kl, input logic [127:0] exp_ct,
                         input string tag, input bit disturb);
    int p, nr, exp_lat, n, bad_round;
    logic [3:0] exp_round;
    bit done;
    p       = 4 / (4 >> sel);
    nr      = (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14;
    exp_lat = 2 + nr * p;
    @(posedge clk);
    #1 next_a[sel] = 1'b0;
    n = 0;
    bad_round = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (ready_a[sel] === 1'b1) begin
        done = 1'b1;
      end else begin
        exp_round = (n == 1) ? 4'd0 : 4'((n - 2) / p + 1);
        if (round_a[sel] !== exp_round) bad_round++;
        if (disturb && n == 4) begin
          next_a[sel]   = 1'b1;
          keylen_a[sel] = ~kl;
        end
        if (disturb && n == 5) next_a[sel] = 1'b0;
      end
    end
    chk({tag, "_latency"}, 128'(n), 128'(exp_lat));
    chk({tag, "_ct"}, nb_a[sel], exp_ct);
    chk({tag, "_round_seq"}, 128'(bad_round), 128'd0);
    chk({tag, "_round_end"}, 128'(round_a[sel]), 128'(nr + 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    pt      = PT;
`ifdef AES_ENC_ABORT_EN
    abort   = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      next_a[i]   = 1'b0;
      keylen_a[i] = 2'd0;
    end
    load_ks(2'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset values on every engine.
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready_%0d", i), 128'(ready_a[i]), 128'd1);
      chk($sformatf("reset_new_block_%0d", i), nb_a[i], 128'd0);
      chk($sformatf("reset_round_%0d", i), 128'(round_a[i]), 128'd0);
      chk($sformatf("reset_state_%0d", i), 128'(st_a[i]), 128'(AES_IDLE));
    end

    // One encryption per engine width / key length.
    kick(0, 2'd0); run_enc(0, 2'd0, CT128, "w4_k128", 1'b0);
    repeat (5) @(negedge clk);
    chk("w4_hold_ct", nb_a[0], CT128);
    chk("w4_hold_ready", 128'(ready_a[0]), 128'd1);

    kick(1, 2'd1); run_enc(1, 2'd1, CT192, "w2_k192", 1'b0);
    kick(2, 2'd2); run_enc(2, 2'd2, CT256, "w1_k256", 1'b0);

    // next pulse and keylen change while busy must not disturb the run.
    @(negedge clk);
    kick(0, 2'd0); run_enc(0, 2'd0, CT128, "w4_busy", 1'b1);

    // Back-to-back: restart in the cycle ready is seen, new key length.
    kick(0, 2'd0); run_enc(0, 2'd0, CT128, "b2b_first", 1'b0);
    kick(0, 2'd2); run_enc(0, 2'd2, CT256, "b2b_second", 1'b0);
    kick(1, 2'd2); run_enc(1, 2'd2, CT256, "b2b_w2_k256", 1'b0);

    // Asynchronous reset in round 5.
    @(negedge clk);
    kick(0, 2'd0);
    @(posedge clk);
    #1 next_a[0] = 1'b0;
    n = 0;
    while (round_a[0] !== 4'd5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_round5", 128'(round_a[0]), 128'd5);
    reset_n = 1'b0;
    #1;
    chk("rst_new_block", nb_a[0], 128'd0);
    chk("rst_round", 128'(round_a[0]), 128'd0);
    chk("rst_ready", 128'(ready_a[0]), 128'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    kick(0, 2'd0); run_enc(0, 2'd0, CT128, "after_reset", 1'b0);

`ifdef AES_ENC_ABORT_EN
    // Abort in round 3, then abort+next in IDLE, then a clean run.
    @(negedge clk);
    kick(1, 2'd1);
    @(posedge clk);
    #1 next_a[1] = 1'b0;
    n = 0;
    while (round_a[1] !== 4'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_round3", 128'(round_a[1]), 128'd3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_ready", 128'(ready_a[1]), 128'd1);
    chk("abort_new_block", nb_a[1], 128'd0);
    chk("abort_round", 128'(round_a[1]), 128'd0);
    next_a[1] = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    next_a[1] = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    chk("abort_next_ignored_ready", 128'(ready_a[1]), 128'd1);
    chk("abort_next_ignored_state", 128'(st_a[1]), 128'(AES_IDLE));
    kick(1, 2'd1); run_enc(1, 2'd1, CT192, "after_abort", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
